// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope generator: VOICES independent voices sharing stage times and sustain.
// Define ADSR_POLY_RETRIG_EN to let gate_on restart ATTACK from the current level in any active stage.
module adsr_poly #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned ENV_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_rate,
  input  logic [VOICES-1:0]         gate_on,
  input  logic [VOICES-1:0]         gate_off,
  input  logic [6:0]                adsr_a,
  input  logic [6:0]                adsr_d,
  input  logic [6:0]                adsr_r,
  input  logic [ENV_W-1:0]          adsr_s,
  output logic [VOICES*ENV_W-1:0]   env_out,
  output logic [VOICES-1:0]         active,
  output logic                      env_dv
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAttack  = 3'd1;
  localparam logic [2:0] StDecay   = 3'd2;
  localparam logic [2:0] StSustain = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  localparam int unsigned ProdW = 2 * ENV_W;
  localparam logic [ENV_W-1:0] EnvMax = '1;

  logic env_dv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_dv_q <= 1'b0;
    end else begin
      env_dv_q <= sample_rate;
    end
  end

  assign env_dv = env_dv_q;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [2:0]       st_q, st_d;
    logic [15:0]      p_q, p_d;
    logic [ENV_W-1:0] l0_q, l0_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W-1:0] scale, mul_a;
    logic [ProdW-1:0] prod;
    logic [6:0]       t;
    logic [7:0]       step;
    logic [16:0]      sum;

    // Output level from registered state; reaches env_out one cycle later.
    always_comb begin
      scale = p_q[15 -: ENV_W];
      mul_a = '0;
      unique case (st_q)
        StAttack:  mul_a = EnvMax - l0_q;
        StDecay:   mul_a = EnvMax - adsr_s;
        StRelease: mul_a = l0_q;
        default:   mul_a = '0;
      endcase
      prod  = ProdW'(mul_a) * ProdW'(scale);
      env_d = '0;
      case (st_q)
        StAttack:  env_d = l0_q + ENV_W'(prod >> ENV_W);
        StDecay:   env_d = EnvMax - ENV_W'(prod >> ENV_W);
        StSustain: env_d = adsr_s;
        StRelease: env_d = l0_q - ENV_W'(prod >> ENV_W);
        default:   env_d = '0;
      endcase
    end

    always_comb begin
      case (st_q)
        StAttack: t = adsr_a;
        StDecay:  t = adsr_d;
        default:  t = adsr_r;
      endcase
      step = 8'd128 - {1'b0, t};
      sum  = {1'b0, p_q} + {9'd0, step};
      st_d = st_q;
      p_d  = p_q;
      l0_d = l0_q;
      // Accepted gate events take priority over the phase step; gate_off beats gate_on.
      if (gate_off[v] && (st_q == StAttack || st_q == StDecay || st_q == StSustain)) begin
        st_d = StRelease;
        p_d  = '0;
        l0_d = env_q;
      end else if (!gate_off[v] && gate_on[v] && st_q == StIdle) begin
        st_d = StAttack;
        p_d  = '0;
        l0_d = '0;
`ifdef ADSR_POLY_RETRIG_EN
      end else if (!gate_off[v] && gate_on[v]) begin
        st_d = StAttack;
        p_d  = '0;
        l0_d = env_q;
`endif
      end else if (sample_rate &&
                   (st_q == StAttack || st_q == StDecay || st_q == StRelease)) begin
        p_d = sum[15:0];
        if (sum[16]) begin
          case (st_q)
            StAttack: st_d = StDecay;
            StDecay:  st_d = StSustain;
            default:  st_d = StIdle;
          endcase
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= StIdle;
        p_q   <= '0;
        l0_q  <= '0;
        env_q <= '0;
      end else begin
        st_q  <= st_d;
        p_q   <= p_d;
        l0_q  <= l0_d;
        env_q <= env_d;
      end
    end

    assign env_out[v*ENV_W +: ENV_W] = env_q;
    assign active[v] = (st_q != StIdle);
  end

endmodule

// File: tb/tb_adsr_poly.sv
// Self-checking bench for adsr_poly: per-cycle reference model plus literal checkpoints.
module tb_adsr_poly;
  localparam int V = 4;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_rate;
  logic [V-1:0] gate_on, gate_off;
  logic [6:0]   adsr_a, adsr_d, adsr_r;
  logic [W-1:0] adsr_s;
  logic [V*W-1:0] env_out;
  logic [V-1:0] active;
  logic         env_dv;

  int n_checks = 0;
  int n_errors = 0;

  adsr_poly #(.VOICES(V), .ENV_W(W)) dut (
    .clk(clk), .rst(rst), .sample_rate(sample_rate),
    .gate_on(gate_on), .gate_off(gate_off),
    .adsr_a(adsr_a), .adsr_d(adsr_d), .adsr_r(adsr_r), .adsr_s(adsr_s),
    .env_out(env_out), .active(active), .env_dv(env_dv)
  );

  always #5 clk = ~clk;

  // Model: stage 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_st[V];
  int m_p[V];
  int m_l0[V];
  int m_env[V];
  int m_dv;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int level(input int st, input int p, input int l0, input int sus);
    int s;
    s = p / (1 << (16 - W));
    case (st)
      1:       return l0 + ((MAXV - l0) * s) / (1 << W);
      2:       return MAXV - ((MAXV - sus) * s) / (1 << W);
      3:       return sus;
      4:       return l0 - (l0 * s) / (1 << W);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_st[v] = 0; m_p[v] = 0; m_l0[v] = 0; m_env[v] = 0;
    end
    m_dv = 0;
  endtask

  task automatic model_step();
    int cur[V];
    int nxt[V];
    int tt;
    for (int v = 0; v < V; v++) begin
      cur[v] = m_env[v];
      nxt[v] = level(m_st[v], m_p[v], m_l0[v], int'(adsr_s));
    end
    for (int v = 0; v < V; v++) begin
      if (gate_off[v] && m_st[v] >= 1 && m_st[v] <= 3) begin
        m_st[v] = 4; m_p[v] = 0; m_l0[v] = cur[v];
      end else if (gate_on[v] && !gate_off[v] && m_st[v] == 0) begin
        m_st[v] = 1; m_p[v] = 0; m_l0[v] = 0;
`ifdef ADSR_POLY_RETRIG_EN
      end else if (gate_on[v] && !gate_off[v]) begin
        m_st[v] = 1; m_p[v] = 0; m_l0[v] = cur[v];
`endif
      end else if (sample_rate && (m_st[v] == 1 || m_st[v] == 2 || m_st[v] == 4)) begin
        tt = (m_st[v] == 1) ? int'(adsr_a) : (m_st[v] == 2) ? int'(adsr_d) : int'(adsr_r);
        m_p[v] = m_p[v] + 128 - tt;
        if (m_p[v] >= 65536) begin
          m_p[v] = m_p[v] - 65536;
          m_st[v] = (m_st[v] == 4) ? 0 : m_st[v] + 1;
        end
      end
    end
    for (int v = 0; v < V; v++) m_env[v] = nxt[v];
    m_dv = int'(sample_rate);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int v = 0; v < V; v++) begin
          chk($sformatf("env_out[%0d]", v), int'(env_out[v*W +: W]), m_env[v]);
          chk($sformatf("active[%0d]", v), int'(active[v]), int'(m_st[v] != 0));
        end
        chk("env_dv", int'(env_dv), m_dv);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    sample_rate = 1'b1;
    gate_on = '0; gate_off = '0;
    adsr_a = 7'd0; adsr_d = 7'd0; adsr_r = 7'd0; adsr_s = 8'd128;
    #1;
    chk("reset env_out", int'(env_out), 0);
    chk("reset active", int'(active), 0);
    chk("reset env_dv", int'(env_dv), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Voice 0 full envelope, A=D=R=0, S=128.
    gate_on = 4'b0001; cyc(1); gate_on = '0;
    cyc(257); chk("attack half", int'(env_out[7:0]), 127);
    cyc(256); chk("attack peak", int'(env_out[7:0]), 255);
    chk("other voices idle", int'(env_out[31:8]), 0);
    cyc(511); chk("last decay", int'(env_out[7:0]), 129);
    cyc(1);   chk("sustain", int'(env_out[7:0]), 128);
    chk("sustain active", int'(active[0]), 1);
    adsr_s = 8'd200; cyc(1); chk("sustain live", int'(env_out[7:0]), 200);
    adsr_s = 8'd128; cyc(1); chk("sustain back", int'(env_out[7:0]), 128);
    gate_off = 4'b0001; cyc(1); gate_off = '0;
    cyc(257); chk("release half", int'(env_out[7:0]), 64);
    cyc(256); chk("release end", int'(env_out[7:0]), 0);
    chk("release inactive", int'(active[0]), 0);

    // gate_on during release at level 64.
    gate_on = 4'b0001; cyc(1); gate_on = '0;
    cyc(1026);
    gate_off = 4'b0001; cyc(1); gate_off = '0;
    cyc(257); chk("rel64", int'(env_out[7:0]), 64);
    gate_on = 4'b0001; cyc(1); gate_on = '0;
    cyc(1); chk("retrig no drop", int'(env_out[7:0]), 64);
    cyc(20);
`ifdef ADSR_POLY_RETRIG_EN
    chk("retrig rising", int'(env_out[7:0] > 8'd64), 1);
`else
    chk("release continues", int'(env_out[7:0] < 8'd64), 1);
`endif
    gate_off = 4'b0001; cyc(1); gate_off = '0;
    cyc(600);

    // Simultaneous gate_on/gate_off on idle voice 2.
    gate_on = 4'b0100; gate_off = 4'b0100; cyc(1);
    gate_on = '0; gate_off = '0; cyc(1);
    chk("v2 env", int'(env_out[23:16]), 0);
    chk("v2 active", int'(active[2]), 0);

    // Asynchronous reset mid-attack on voice 1.
    gate_on = 4'b0010; cyc(1); gate_on = '0;
    cyc(99); chk("v1 mid attack", int'(env_out[15:8]), 48);
    rst = 1'b1; #1;
    chk("async rst env_out", int'(env_out), 0);
    chk("async rst active", int'(active), 0);
    chk("async rst env_dv", int'(env_dv), 0);
    cyc(1); rst = 1'b0; cyc(1);
    gate_on = 4'b0010; cyc(1); gate_on = '0;
    cyc(1); chk("post rst start", int'(env_out[15:8]), 0);
    cyc(5);
    gate_off = 4'b0010; cyc(1); gate_off = '0;

    // Mixed traffic on all voices with sparse ticks and varying sustain.
    adsr_a = 7'd5; adsr_d = 7'd3; adsr_r = 7'd2; adsr_s = 8'd90;
    for (int i = 0; i < 3000; i++) begin
      sample_rate = ($urandom_range(0, 3) != 0);
      gate_on  = (i % 97 == 0)  ? 4'($urandom_range(0, 15)) : 4'b0000;
      gate_off = (i % 131 == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (i == 1000) adsr_s = 8'd255;
      if (i == 1500) adsr_s = 8'd0;
      if (i == 2300) adsr_s = 8'd37;
      cyc(1);
    end
    gate_on = '0; sample_rate = 1'b1;
    gate_off = '1; cyc(1); gate_off = '0;
    cyc(700);
    chk("all idle", int'(active), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
